// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer
// Majority-vote debouncer for N push buttons. A single window counter is
// shared by all channels. Each channel synchronises its raw pin, counts high
// samples over the window and, at the terminal cycle of the window, feeds the
// vote into a small IDLE/PRESSED/HELD state machine. That state machine
// drives a registered level and one-cycle press/release/held pulses.
// Per-channel state is exported on state_dbg_o, two bits per channel, so
// checkers can observe it.

module multi_button_debouncer #(
    parameter int N_BUTTONS    = 4,
    parameter int WINDOW       = 100000,
    parameter int THRESHOLD    = 50000,
    parameter int HOLD_WINDOWS = 200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BUTTONS-1:0]   button_raw_i,
    output logic [N_BUTTONS-1:0]   level_o,
    output logic [N_BUTTONS-1:0]   press_o,
    output logic [N_BUTTONS-1:0]   release_o,
    output logic [N_BUTTONS-1:0]   held_o,
    output logic                   window_tick_o,
    output logic [2*N_BUTTONS-1:0] state_dbg_o
);

    // Counter widths: the sample counter must hold WINDOW itself, and the
    // hold counter must hold HOLD_WINDOWS itself.
    localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int CNT_W  = $clog2(WINDOW + 1);
    localparam int HOLD_W = $clog2(HOLD_WINDOWS + 1);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  THRESH_C  = CNT_W'(THRESHOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_WINDOWS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    // Two-flop synchroniser; sync2_q is the only view of the pins used below.
    logic [N_BUTTONS-1:0] sync1_q;
    logic [N_BUTTONS-1:0] sync2_q;

    // Shared window counter and the registered tick.
    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic              terminal;
    logic              tick_q;

    // Per-channel sample counters and votes.
    logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_d [N_BUTTONS];
    logic [CNT_W-1:0]     cnt_sum [N_BUTTONS];
    logic [N_BUTTONS-1:0] vote;

    // Per-channel state machine state and registered outputs.
    btn_state_e           state_q [N_BUTTONS];
    logic [HOLD_W-1:0]    hold_cnt_q [N_BUTTONS];
    logic [N_BUTTONS-1:0] level_q;
    logic [N_BUTTONS-1:0] press_q;
    logic [N_BUTTONS-1:0] release_q;
    logic [N_BUTTONS-1:0] held_q;

    // Bring the asynchronous pins into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= button_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // The window counter wraps after its terminal cycle.
    always_comb begin
        terminal = (wcnt_q == WCNT_LAST);
        wcnt_d   = terminal ? '0 : wcnt_q + WCNT_W'(1);
    end

    // Advance the shared window counter; the tick follows the terminal cycle by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            tick_q <= terminal;
        end
    end

    // The running sum includes the current sample, so the terminal sample
    // counts towards the vote before the counter is cleared.
    always_comb begin
        vote = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_sum[i] = cnt_q[i] + CNT_W'(sync2_q[i]);
            vote[i]    = (cnt_sum[i] >= THRESH_C);
            cnt_d[i]   = terminal ? '0 : cnt_sum[i];
        end
    end

    // Accumulate high samples per channel across the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Per-channel press/hold state machine, stepped once per window on the terminal cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BUTTONS; i++) begin
                state_q[i]    <= ST_IDLE;
                hold_cnt_q[i] <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            held_q    <= '0;
        end else begin
            // Pulses are single-cycle: cleared every cycle unless set below.
            press_q   <= '0;
            release_q <= '0;
            held_q    <= '0;
            if (terminal) begin
                for (int i = 0; i < N_BUTTONS; i++) begin
                    case (state_q[i])
                        ST_IDLE: begin
                            if (vote[i]) begin
                                state_q[i]    <= ST_PRESSED;
                                press_q[i]    <= 1'b1;
                                level_q[i]    <= 1'b1;
                                hold_cnt_q[i] <= HOLD_ONE;
                            end
                        end
                        ST_PRESSED: begin
                            if (vote[i]) begin
                                hold_cnt_q[i] <= hold_cnt_q[i] + HOLD_ONE;
                                if ((hold_cnt_q[i] + HOLD_ONE) == HOLD_LAST) begin
                                    held_q[i]  <= 1'b1;
                                    state_q[i] <= ST_HELD;
                                end
                            end else begin
                                state_q[i]    <= ST_IDLE;
                                release_q[i]  <= 1'b1;
                                level_q[i]    <= 1'b0;
                                hold_cnt_q[i] <= '0;
                            end
                        end
                        ST_HELD: begin
                            // Hold count stays at HOLD_WINDOWS; only a low vote leaves.
                            if (!vote[i]) begin
                                state_q[i]    <= ST_IDLE;
                                release_q[i]  <= 1'b1;
                                level_q[i]    <= 1'b0;
                                hold_cnt_q[i] <= '0;
                            end
                        end
                        default: begin
                            state_q[i]    <= ST_IDLE;
                            level_q[i]    <= 1'b0;
                            hold_cnt_q[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Pack per-channel state for observation.
    always_comb begin
        state_dbg_o = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            state_dbg_o[2*i +: 2] = state_q[i];
        end
    end

    assign level_o       = level_q;
    assign press_o       = press_q;
    assign release_o     = release_q;
    assign held_o        = held_q;
    assign window_tick_o = tick_q;

endmodule
